// File: rtl/qs_pkg.sv
// Shared types and constants for the quicksort sequencer and its range stack.
package qs_pkg;

  localparam int IDX_W  = 4;
  localparam int ELEM_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
  } range_t;

  function automatic range_t make_range(input logic [IDX_W-1:0] lo,
                                        input logic [IDX_W-1:0] hi);
    range_t r;
    r.lo = lo;
    r.hi = hi;
    return r;
  endfunction

endpackage

// File: rtl/qs_range_stack.sv
// LIFO of pending {lo,hi} ranges; two pushes per cycle (push1 lands on top),
// a synchronous clear that may accompany push0, and an overflow pulse when a push is dropped.
module qs_range_stack
  import qs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_clear,
  input  logic   i_push0,
  input  range_t i_data0,
  input  logic   i_push1,
  input  range_t i_data1,
  input  logic   i_pop,
  output range_t o_top,
  output logic   o_empty,
  output logic   o_overflow
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH_C = SP_W'(DEPTH);

  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_base;
  logic [SP_W-1:0] w_base1;
  logic            w_ok0;
  logic            w_ok1;
  range_t          r_mem [DEPTH];

  assign w_base     = i_clear ? '0 : r_sp;
  assign w_ok0      = i_push0 && (w_base < DEPTH_C);
  assign w_base1    = w_base + SP_W'(w_ok0);
  assign w_ok1      = i_push1 && (w_base1 < DEPTH_C);
  assign o_overflow = (i_push0 && !w_ok0) || (i_push1 && !w_ok1);
  assign o_empty    = (r_sp == '0);
  assign o_top      = r_mem[AW'(r_sp - SP_W'(1))];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= '0;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end else begin
      r_sp <= w_base1 + SP_W'(w_ok1);
    end
  end

  // NOTE: storage has no reset; the pointer alone defines which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_ok0) r_mem[AW'(w_base)]  <= i_data0;
    if (w_ok1) r_mem[AW'(w_base1)] <= i_data1;
  end

endmodule

// File: rtl/quicksort_ctrl.sv
// Quicksort sequencer around one external Lomuto partition block.
// Optional watchdog on the partition wait: define QS_TIMEOUT_EN.
module quicksort_ctrl
  import qs_pkg::*;
#(
  parameter int ARR_WIDTH   = 4,
  parameter int STACK_DEPTH = 4
`ifdef QS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
  output logic [ARR_WIDTH*ELEM_W-1:0] array_out,
  output logic                        done,
  output logic                        busy,
  output logic                        err,
  output logic                        part_start,
  output logic [IDX_W-1:0]            part_lo,
  output logic [IDX_W-1:0]            part_hi,
  output logic [IDX_W-1:0]            part_pivot_ind,
  output logic [ARR_WIDTH*ELEM_W-1:0] part_array,
  input  logic [ARR_WIDTH*ELEM_W-1:0] part_array_ret,
  input  logic                        part_valid,
  input  logic [IDX_W-1:0]            part_pivot_ret
);

  localparam int AW_BITS = ARR_WIDTH * ELEM_W;

  state_t               r_state, w_state_nxt;
  logic [AW_BITS-1:0]   r_arr, r_out;
  logic [IDX_W-1:0]     r_lo, r_hi, r_p;
  logic                 r_err;

  logic                 w_clear, w_push0, w_push1, w_pop;
  range_t               w_data0, w_data1, w_top;
  logic                 w_empty, w_overflow;
  logic                 w_bad_p, w_left, w_right, w_timeout, w_set_err;

  qs_range_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_clear    (w_clear),
    .i_push0    (w_push0),
    .i_data0    (w_data0),
    .i_push1    (w_push1),
    .i_data1    (w_data1),
    .i_pop      (w_pop),
    .o_top      (w_top),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  // Compare in 5 bits so p-1 / p+1 are only formed when they cannot wrap.
  assign w_bad_p = (r_p < r_lo) || (r_p > r_hi);
  assign w_left  = {1'b0, r_p} > ({1'b0, r_lo} + 5'd1);
  assign w_right = ({1'b0, r_p} + 5'd1) < {1'b0, r_hi};

`ifdef QS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_timer;

  assign w_timeout = (r_timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_timer <= '0;
    else if (r_state == ISSUE) r_timer <= '0;
    else if (r_state == WAIT)  r_timer <= r_timer + TW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_pop       = 1'b0;
    w_data0     = '0;
    w_data1     = '0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_push0     = 1'b1;
          w_data0     = make_range('0, IDX_W'(ARR_WIDTH - 1));
          w_state_nxt = POP;
        end
      end
      POP: begin
        if (w_empty) begin
          w_state_nxt = DONE;
        end else begin
          w_pop = 1'b1;
          if (w_top.lo < w_top.hi) w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (part_valid)     w_state_nxt = PUSH;
        else if (w_timeout) w_state_nxt = DONE;
      end
      PUSH: begin
        if (w_bad_p) begin
          w_state_nxt = DONE;
        end else begin
          w_push0     = w_left;
          w_data0     = make_range(r_lo, r_p - 4'd1);
          w_push1     = w_right;
          w_data1     = make_range(r_p + 4'd1, r_hi);
          w_state_nxt = w_overflow ? DONE : POP;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_set_err = ((r_state == PUSH) && (w_bad_p || w_overflow)) ||
                     ((r_state == WAIT) && !part_valid && w_timeout);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_arr   <= '0;
      r_out   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_p     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_arr <= array_in;
        r_err <= 1'b0;
      end
      if ((r_state == POP) && !w_empty) begin
        r_lo <= w_top.lo;
        r_hi <= w_top.hi;
      end
      if ((r_state == WAIT) && part_valid) begin
        r_arr <= part_array_ret;
        r_p   <= part_pivot_ret;
      end
      if (w_set_err) r_err <= 1'b1;
      if ((w_state_nxt == DONE) && (r_state != DONE)) r_out <= r_arr;
    end
  end

  assign array_out      = r_out;
  assign done           = (r_state == DONE);
  assign busy           = (r_state == POP) || (r_state == ISSUE) ||
                          (r_state == WAIT) || (r_state == PUSH);
  assign err            = r_err;
  assign part_start     = (r_state == ISSUE);
  assign part_lo        = r_lo;
  assign part_hi        = r_hi;
  assign part_pivot_ind = r_hi;
  assign part_array     = r_arr;

endmodule

// File: tb/tb_quicksort_ctrl.sv
// Bench for quicksort_ctrl with a behavioural Lomuto partition responder per instance.
module tb_quicksort_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // Instance A: 4 elements, default stack.
  logic        start = 1'b0;
  logic [15:0] array_in = '0, array_out, part_array, part_array_ret = '0;
  logic        done, busy, err, part_start, part_valid = 1'b0;
  logic [3:0]  part_lo, part_hi, part_pivot_ind, part_pivot_ret = '0;

  // Instance B: 6 elements, single-entry stack.
  logic        b_start = 1'b0;
  logic [23:0] b_array_in = '0, b_array_out, b_part_array, b_part_array_ret = '0;
  logic        b_done, b_busy, b_err, b_part_start, b_part_valid = 1'b0;
  logic [3:0]  b_part_lo, b_part_hi, b_part_pivot_ind, b_part_pivot_ret = '0;

  int tests_run = 0, tests_failed = 0;
  int done_cnt = 0, b_done_cnt = 0, bad_issue = 0;
  bit stub = 1'b0;

  always #5 clock = ~clock;

  quicksort_ctrl dut_a (
    .clock(clock), .reset(reset), .start(start), .array_in(array_in),
    .array_out(array_out), .done(done), .busy(busy), .err(err),
    .part_start(part_start), .part_lo(part_lo), .part_hi(part_hi),
    .part_pivot_ind(part_pivot_ind), .part_array(part_array),
    .part_array_ret(part_array_ret), .part_valid(part_valid),
    .part_pivot_ret(part_pivot_ret)
  );

  quicksort_ctrl #(.ARR_WIDTH(6), .STACK_DEPTH(1)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .array_in(b_array_in),
    .array_out(b_array_out), .done(b_done), .busy(b_busy), .err(b_err),
    .part_start(b_part_start), .part_lo(b_part_lo), .part_hi(b_part_hi),
    .part_pivot_ind(b_part_pivot_ind), .part_array(b_part_array),
    .part_array_ret(b_part_array_ret), .part_valid(b_part_valid),
    .part_pivot_ret(b_part_pivot_ret)
  );

  function automatic logic [3:0] lomuto(input int n, input logic [63:0] a_in,
                                        input int lo, input int hi,
                                        output logic [63:0] a_out);
    logic [3:0] e [16];
    logic [3:0] pv, t;
    int i;
    for (int k = 0; k < 16; k++) e[k] = '0;
    for (int k = 0; k < n; k++) e[k] = a_in[(n-1-k)*4 +: 4];
    pv = e[hi];
    i  = lo;
    for (int j = lo; j < hi; j++) begin
      if (e[j] <= pv) begin
        t = e[i]; e[i] = e[j]; e[j] = t;
        i++;
      end
    end
    t = e[i]; e[i] = e[hi]; e[hi] = t;
    a_out = '0;
    for (int k = 0; k < n; k++) a_out[(n-1-k)*4 +: 4] = e[k];
    return 4'(i);
  endfunction

  logic [63:0] ra_tmp, rb_tmp;
  logic [3:0]  ra_p, rb_p;

  always begin
    @(negedge clock);
    if (part_start && !stub) begin
      ra_p = lomuto(4, {48'd0, part_array}, int'(part_lo), int'(part_hi), ra_tmp);
      @(negedge clock);
      @(negedge clock);
      part_array_ret = ra_tmp[15:0];
      part_pivot_ret = ra_p;
      part_valid     = 1'b1;
      @(negedge clock);
      part_valid     = 1'b0;
    end
  end

  always begin
    @(negedge clock);
    if (b_part_start) begin
      rb_p = lomuto(6, {40'd0, b_part_array}, int'(b_part_lo), int'(b_part_hi), rb_tmp);
      @(negedge clock);
      @(negedge clock);
      b_part_array_ret = rb_tmp[23:0];
      b_part_pivot_ret = rb_p;
      b_part_valid     = 1'b1;
      @(negedge clock);
      b_part_valid     = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (b_done) b_done_cnt++;
    if (part_start && ((part_lo >= part_hi) || (part_pivot_ind !== part_hi))) bad_issue++;
  end

  task automatic run_a(input logic [15:0] a, output logic [15:0] res, output logic e,
                       output int pulses, output bit ok);
    int d0;
    d0 = done_cnt; res = '0; e = 1'b0; ok = 1'b0;
    @(negedge clock); array_in = a; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      if (done) begin ok = 1'b1; res = array_out; e = err; end
      else @(negedge clock);
    end
    repeat (4) @(negedge clock);
    pulses = done_cnt - d0;
  endtask

  task automatic run_b(input logic [23:0] a, output logic [23:0] res, output logic e,
                       output int pulses, output bit ok);
    int d0;
    d0 = b_done_cnt; res = '0; e = 1'b0; ok = 1'b0;
    @(negedge clock); b_array_in = a; b_start = 1'b1;
    @(negedge clock); b_start = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      if (b_done) begin ok = 1'b1; res = b_array_out; e = b_err; end
      else @(negedge clock);
    end
    repeat (4) @(negedge clock);
    pulses = b_done_cnt - d0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({done, busy, err, part_start, part_lo, part_hi, part_pivot_ind} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h required 0", {done, busy, err, part_start, part_lo, part_hi, part_pivot_ind});
    end
    tests_run++;
    if ({array_out, part_array} !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_arrays: got %h required 0", {array_out, part_array});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    logic [15:0] res; logic e; int pulses; bit ok;
    run_a(16'h3120, res, e, pulses, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL basic_done: no done within budget"); end
    tests_run++;
    if (res !== 16'h0123) begin tests_failed++; $display("FAIL basic_result: got %h required 0123", res); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b required 0", e); end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL basic_pulses: got %0d required 1", pulses); end
  endtask

  task automatic test_sorted;
    logic [15:0] res; logic e; int pulses; bit ok;
    bad_issue = 0;
    run_a(16'h0123, res, e, pulses, ok);
    tests_run++;
    if (res !== 16'h0123 || ok !== 1'b1) begin tests_failed++; $display("FAIL sorted_result: got %h required 0123", res); end
    tests_run++;
    if (bad_issue !== 0) begin tests_failed++; $display("FAIL sorted_issue_lo_lt_hi: got %0d bad issues required 0", bad_issue); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL sorted_err: got %b required 0", e); end
  endtask

  task automatic test_equal;
    logic [15:0] res; logic e; int pulses; bit ok;
    run_a(16'h5555, res, e, pulses, ok);
    tests_run++;
    if (ok !== 1'b1 || res !== 16'h5555) begin tests_failed++; $display("FAIL equal_result: got %h required 5555", res); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL equal_err: got %b required 0", e); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] res; logic e; int d0; bit ok;
    res = '0; e = 1'b0; ok = 1'b0; d0 = done_cnt;
    @(negedge clock); array_in = 16'h3120; start = 1'b1;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; res = array_out; e = err; start = 1'b0; end
    end
    start = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++;
    if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL b2b_pulses: got %0d required 1", done_cnt - d0); end
    tests_run++;
    if (res !== 16'h0123 || e !== 1'b0) begin tests_failed++; $display("FAIL b2b_result: got %h err %b required 0123 err 0", res, e); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res; logic e; int pulses, d0; bit ok, seen;
    seen = 1'b0;
    @(negedge clock); array_in = 16'h3120; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (part_start) seen = 1'b1;
      else @(negedge clock);
    end
    tests_run++;
    if (seen !== 1'b1) begin tests_failed++; $display("FAIL rstmid_issue: no part_start within budget"); end
    @(negedge clock);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({done, busy, err, part_start, part_lo, part_hi, part_pivot_ind} !== 15'd0 ||
        {array_out, part_array} !== 32'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got %h %h required 0", {done, busy, err, part_start, part_lo, part_hi, part_pivot_ind}, {array_out, part_array});
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++;
    if (done_cnt !== d0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d extra pulses busy %b required 0", done_cnt - d0, busy); end
    run_a(16'h2301, res, e, pulses, ok);
    tests_run++;
    if (ok !== 1'b1 || res !== 16'h0123 || e !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_resort: got %h err %b required 0123 err 0", res, e);
    end
  endtask

  task automatic test_overflow;
    logic [23:0] res; logic e; int pulses; bit ok;
    run_b(24'h012543, res, e, pulses, ok);
    tests_run++;
    if (ok !== 1'b1 || pulses !== 1) begin tests_failed++; $display("FAIL ovf_done: got %0d pulses required 1", pulses); end
    tests_run++;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL ovf_err: got %b required 1", e); end
  endtask

  task automatic test_err_clear;
    logic [23:0] res; logic e; int pulses; bit ok;
    run_b(24'h000000, res, e, pulses, ok);
    tests_run++;
    if (ok !== 1'b1 || e !== 1'b0 || res !== 24'h000000) begin
      tests_failed++; $display("FAIL errclr: got %h err %b required 000000 err 0", res, e);
    end
  endtask

`ifdef QS_TIMEOUT_EN
  task automatic test_timeout;
    int cnt; bit seen, fin; logic e;
    seen = 1'b0; fin = 1'b0; cnt = 0; e = 1'b0;
    stub = 1'b1;
    @(negedge clock); array_in = 16'h3120; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (part_start) seen = 1'b1;
      else @(negedge clock);
    end
    for (int c = 0; c < 200 && !fin && seen; c++) begin
      @(negedge clock);
      cnt++;
      if (done) begin fin = 1'b1; e = err; end
    end
    stub = 1'b0;
    repeat (4) @(negedge clock);
    tests_run++;
    if (fin !== 1'b1 || cnt !== 65) begin tests_failed++; $display("FAIL timeout_latency: got %0d cycles after issue required 65", cnt); end
    tests_run++;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL timeout_err: got %b required 1", e); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_sorted();
    test_equal();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_err_clear();
`ifdef QS_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
